hazard_control: RTL and testbench

Pipeline hazard and stall controller for the five-stage RISC-V core. It sits beside the decode/execute boundary, directly upstream of the operand forwarding unit. It covers the hazards forwarding cannot resolve: load-use dependences, taken-branch redirects and data-memory wait states. It drives per-stage enable, flush and bubble controls, tracks a saturating stall-cycle counter, and raises a sticky memory-timeout flag.

---
 rtl/hazard_control.sv | 156 +++++++++++++++
 tb/tb_hazard_control.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control.sv
// Pipeline hazard and stall controller: load-use stalls, taken-branch redirect
// flushes and data-memory wait states, with a saturating stall counter and a
// sticky memory-timeout flag.
module hazard_control #(
  parameter int unsigned REDIRECT_FLUSH_CYCLES = 1,
  parameter int unsigned MEMORY_TIMEOUT        = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  decode_register_number_a,
  input  logic        decode_read_a,
  input  logic [4:0]  decode_register_number_b,
  input  logic        decode_read_b,
  input  logic [4:0]  execute_destination_register_number,
  input  logic        execute_write_enable,
  input  logic        execute_is_load,
  input  logic        execute_branch_taken,
  input  logic        memory_request_valid,
  input  logic        memory_ready,
  output logic        fetch_enable,
  output logic        decode_enable,
  output logic        decode_flush,
  output logic        execute_enable,
  output logic        execute_bubble,
  output logic        memory_hold,
  output logic        write_back_bubble,
  output logic        memory_timeout,
  output logic [31:0] stall_cycle_count
);

  // Redirect counter only ever holds REDIRECT_FLUSH_CYCLES-1 and below.
  localparam int unsigned RedirectWidth =
      (REDIRECT_FLUSH_CYCLES > 1) ? $clog2(REDIRECT_FLUSH_CYCLES) : 1;
  localparam int unsigned WaitWidth = $clog2(MEMORY_TIMEOUT + 1);

  localparam logic [RedirectWidth-1:0] RedirectLoad = RedirectWidth'(REDIRECT_FLUSH_CYCLES - 1);
  localparam logic [RedirectWidth-1:0] RedirectOne  = RedirectWidth'(1);
  localparam logic [WaitWidth-1:0]     WaitLast     = WaitWidth'(MEMORY_TIMEOUT - 1);
  localparam logic [WaitWidth-1:0]     WaitMax      = WaitWidth'(MEMORY_TIMEOUT);
  localparam logic [WaitWidth-1:0]     WaitOne      = WaitWidth'(1);

  typedef enum logic [1:0] {StRun, StRedirect, StMemoryWait} state_e;

  state_e                   state_q, state_d;
  state_e                   saved_q, saved_d;
  state_e                   active_state;
  logic [RedirectWidth-1:0] redirect_q, redirect_d;
  logic [WaitWidth-1:0]     wait_q, wait_d;
  logic                     timeout_q, timeout_d;
  logic [31:0]              stall_q, stall_d;
  logic                     memory_wait;
  logic                     load_use;

  assign memory_wait = memory_request_valid && !memory_ready;

  // While frozen in a memory wait, the pipeline behaves as the state it left.
  assign active_state = (state_q == StMemoryWait) ? saved_q : state_q;

  assign load_use = execute_is_load && execute_write_enable &&
                    (execute_destination_register_number != 5'd0) &&
                    ((decode_read_a &&
                      (decode_register_number_a == execute_destination_register_number)) ||
                     (decode_read_b &&
                      (decode_register_number_b == execute_destination_register_number)));

  assign memory_timeout    = timeout_q;
  assign stall_cycle_count = stall_q;

  // State, counters and flags; reset abandons any wait or redirect in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StRun;
      saved_q    <= StRun;
      redirect_q <= '0;
      wait_q     <= '0;
      timeout_q  <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      saved_q    <= saved_d;
      redirect_q <= redirect_d;
      wait_q     <= wait_d;
      timeout_q  <= timeout_d;
      stall_q    <= stall_d;
    end
  end

  // Next state and redirect countdown, in hazard priority order.
  always_comb begin
    state_d    = state_q;
    saved_d    = saved_q;
    redirect_d = redirect_q;
    if (memory_wait) begin
      state_d = StMemoryWait;
      saved_d = active_state;
    end else if (execute_branch_taken) begin
      redirect_d = RedirectLoad;
      state_d    = (RedirectLoad != '0) ? StRedirect : StRun;
    end else if (active_state == StRedirect) begin
      redirect_d = (redirect_q == '0) ? '0 : redirect_q - RedirectOne;
      state_d    = ((redirect_q == RedirectOne) || (redirect_q == '0)) ? StRun : StRedirect;
    end else begin
      state_d = StRun;
    end
  end

  // Wait counter, sticky timeout and saturating stall counter.
  always_comb begin
    wait_d    = '0;
    timeout_d = timeout_q;
    stall_d   = stall_q;
    if (memory_wait) begin
      wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitOne;
      if (wait_q == WaitLast) begin
        timeout_d = 1'b1;
      end
    end
    if (!fetch_enable && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  // Pipeline controls, combinational so a hazard stalls in the cycle it appears.
  always_comb begin
    fetch_enable      = 1'b1;
    decode_enable     = 1'b1;
    decode_flush      = 1'b0;
    execute_enable    = 1'b1;
    execute_bubble    = 1'b0;
    memory_hold       = 1'b0;
    write_back_bubble = 1'b0;
    if (reset) begin
      fetch_enable   = 1'b0;
      decode_enable  = 1'b0;
      decode_flush   = 1'b1;
      execute_enable = 1'b0;
      execute_bubble = 1'b1;
    end else if (memory_wait) begin
      fetch_enable      = 1'b0;
      decode_enable     = 1'b0;
      execute_enable    = 1'b0;
      memory_hold       = 1'b1;
      write_back_bubble = 1'b1;
    end else if (execute_branch_taken) begin
      decode_flush   = 1'b1;
      execute_bubble = 1'b1;
    end else if (active_state == StRedirect) begin
      decode_flush = 1'b1;
    end else if (load_use) begin
      fetch_enable   = 1'b0;
      decode_enable  = 1'b0;
      execute_bubble = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed scenarios plus randomized traffic, all
// checked against a behavioural model of flush slots, wait runs and stalls.
module tb_hazard_control;

  localparam int unsigned Redirect   = 3;
  localparam int unsigned MemTimeout = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd;
  logic        read_a, read_b, we, is_load, branch, mem_valid, mem_ready;
  logic        fetch_enable, decode_enable, decode_flush, execute_enable;
  logic        execute_bubble, memory_hold, write_back_bubble, memory_timeout;
  logic [31:0] stall_cycle_count;
  logic [6:0]  ctl;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model state: flushed decode slots still owed, current wait run length,
  // sticky timeout, fetch-stalled cycles.
  int          m_flush_left, n_flush_left;
  int          m_wait, n_wait;
  logic        m_timeout, n_timeout;
  logic [31:0] m_stalls, n_stalls;
  logic [6:0]  exp_ctl;

  hazard_control #(
    .REDIRECT_FLUSH_CYCLES(Redirect),
    .MEMORY_TIMEOUT       (MemTimeout)
  ) dut (
    .clock                              (clock),
    .reset                              (reset),
    .decode_register_number_a           (rs1),
    .decode_read_a                      (read_a),
    .decode_register_number_b           (rs2),
    .decode_read_b                      (read_b),
    .execute_destination_register_number(rd),
    .execute_write_enable               (we),
    .execute_is_load                    (is_load),
    .execute_branch_taken               (branch),
    .memory_request_valid               (mem_valid),
    .memory_ready                       (mem_ready),
    .fetch_enable                       (fetch_enable),
    .decode_enable                      (decode_enable),
    .decode_flush                       (decode_flush),
    .execute_enable                     (execute_enable),
    .execute_bubble                     (execute_bubble),
    .memory_hold                        (memory_hold),
    .write_back_bubble                  (write_back_bubble),
    .memory_timeout                     (memory_timeout),
    .stall_cycle_count                  (stall_cycle_count)
  );

  always #5 clock = ~clock;

  assign ctl = {fetch_enable, decode_enable, decode_flush, execute_enable,
                execute_bubble, memory_hold, write_back_bubble};

  task automatic drive(input logic r, input logic [4:0] a, input logic ra,
                       input logic [4:0] b, input logic rb, input logic [4:0] d,
                       input logic w, input logic ld, input logic br,
                       input logic mv, input logic mr);
    reset = r; rs1 = a; read_a = ra; rs2 = b; read_b = rb; rd = d;
    we = w; is_load = ld; branch = br; mem_valid = mv; mem_ready = mr;
  endtask

  // Expected controls for the present inputs, and the model's next state.
  task automatic model_eval();
    logic lu;
    lu = is_load && we && (rd != 5'd0) &&
         ((read_a && (rs1 == rd)) || (read_b && (rs2 == rd)));
    n_flush_left = m_flush_left;
    n_wait       = 0;
    n_timeout    = m_timeout;
    n_stalls     = m_stalls;
    if (reset) begin
      exp_ctl      = 7'b0010100;
      n_flush_left = 0;
      n_timeout    = 1'b0;
      n_stalls     = '0;
    end else if (mem_valid && !mem_ready) begin
      exp_ctl = 7'b0000011;
      n_wait  = m_wait + 1;
      if (n_wait >= int'(MemTimeout)) n_timeout = 1'b1;
    end else if (branch) begin
      exp_ctl      = 7'b1111100;
      n_flush_left = Redirect - 1;
    end else if (m_flush_left > 0) begin
      exp_ctl      = 7'b1111000;
      n_flush_left = m_flush_left - 1;
    end else if (lu) begin
      exp_ctl = 7'b0001100;
    end else begin
      exp_ctl = 7'b1101000;
    end
    if (!reset && !exp_ctl[6] && (n_stalls != 32'hFFFF_FFFF)) n_stalls = n_stalls + 1;
  endtask

  task automatic advance();
    @(posedge clock);
    m_flush_left = n_flush_left;
    m_wait       = n_wait;
    m_timeout    = n_timeout;
    m_stalls     = n_stalls;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL reset_ctl: got %b expected %b", ctl, exp_ctl);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clock);
    n_cmp++;
    if (stall_cycle_count !== 32'd0 || memory_timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_state: got count %0d timeout %b expected 0 0",
                         stall_cycle_count, memory_timeout);
    end
    model_eval();
    n_cmp++;
    if (ctl !== exp_ctl) begin
      n_fail++; $display("FAIL reset_idle_ctl: got %b expected %b", ctl, exp_ctl);
    end
    advance();
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(0, 3, 1, 5, 1, 5, 1, 1, 0, 0, 0);
      else        drive(0, 3, 1, 5, 1, 9, 1, 0, 0, 0, 0);
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL load_use_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      n_cmp++;
      if (stall_cycle_count !== m_stalls) begin
        n_fail++; $display("FAIL load_use_count[%0d]: got %0d expected %0d",
                           i, stall_cycle_count, m_stalls);
      end
      advance();
    end
  endtask

  task automatic test_x0_and_unused();
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive(0, 0, 1, 0, 1, 0, 1, 1, 0, 0, 0);
        1:       drive(0, 7, 0, 2, 1, 7, 1, 1, 0, 0, 0);
        default: drive(0, 4, 1, 7, 0, 7, 1, 1, 0, 0, 0);
      endcase
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl || ctl !== 7'b1101000) begin
        n_fail++; $display("FAIL no_stall_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    int flushes;
    flushes = 0;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 2, 1, 6, 1, 0, i == 0, 0, 0);
      @(negedge clock);
      model_eval();
      if (decode_flush === 1'b1) flushes++;
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL redirect_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      advance();
    end
    n_cmp++;
    if (flushes != int'(Redirect)) begin
      n_fail++; $display("FAIL redirect_flush_count: got %0d expected %0d", flushes, Redirect);
    end
  endtask

  task automatic test_memory_wait();
    // 4-cycle wait, then branch + wait in its second redirect cycle, then
    // branch arriving together with a wait.
    for (int i = 0; i < 19; i++) begin
      case (i)
        0, 1, 2, 3:     drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        4:              drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        5:              drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        7, 8, 9:        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        13, 14:         drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        15:             drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        default:        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL mem_wait_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      n_cmp++;
      if (stall_cycle_count !== m_stalls) begin
        n_fail++; $display("FAIL mem_wait_count[%0d]: got %0d expected %0d",
                           i, stall_cycle_count, m_stalls);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      if (i < 10)       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      else if (i == 14) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      else              drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (memory_timeout !== m_timeout) begin
        n_fail++; $display("FAIL timeout_flag[%0d]: got %b expected %b",
                           i, memory_timeout, m_timeout);
      end
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL timeout_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid_operation();
    for (int i = 0; i < 8; i++) begin
      case (i)
        0, 1, 2: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        3:       drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        4:       drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        5:       drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        default: drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      endcase
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL reset_mid_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      n_cmp++;
      if (stall_cycle_count !== m_stalls || memory_timeout !== m_timeout) begin
        n_fail++; $display("FAIL reset_mid_state[%0d]: got %0d/%b expected %0d/%b", i,
                           stall_cycle_count, memory_timeout, m_stalls, m_timeout);
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 64) == 0,
            5'($urandom % 4), 1'($urandom % 2),
            5'($urandom % 4), 1'($urandom % 2),
            5'($urandom % 4), 1'(($urandom % 4) != 0), 1'($urandom % 2),
            ($urandom % 6) == 0, ($urandom % 3) == 0, 1'($urandom % 2));
      if ((i / 100) % 2 == 1 && mem_valid) mem_ready = (($urandom % 8) == 0);
      @(negedge clock);
      model_eval();
      n_cmp++;
      if (ctl !== exp_ctl) begin
        n_fail++; $display("FAIL random_ctl[%0d]: got %b expected %b", i, ctl, exp_ctl);
      end
      n_cmp++;
      if (stall_cycle_count !== m_stalls || memory_timeout !== m_timeout) begin
        n_fail++; $display("FAIL random_state[%0d]: got %0d/%b expected %0d/%b", i,
                           stall_cycle_count, memory_timeout, m_stalls, m_timeout);
      end
      advance();
    end
  endtask

  initial begin
    m_flush_left = 0;
    m_wait       = 0;
    m_timeout    = 1'b0;
    m_stalls     = '0;
    test_reset();
    test_load_use();
    test_x0_and_unused();
    test_redirect();
    test_memory_wait();
    test_timeout();
    test_reset_mid_operation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
